// File: rtl/cell_bist_ctrl.sv
// cell_bist_ctrl: BIST controller for the standard-cell test bank.
//
// Drives N_PAT pseudo-random 8-bit patterns from a Fibonacci LFSR into the
// cell bank, then flushes for LAT cycles while the bank pipeline drains.
// The 16-bit bank response is compacted into a MISR (CRC-16/CCITT feedback).
// On the final capture the signature is compared against GOLDEN.
//
// Optional feature: define CELL_BIST_DIAG_EN to add the SIG output carrying
// the final signature. Without it, only PASS reports the result.
//
// Ports:
//   CLK    in   1   rising-edge clock
//   RST    in   1   synchronous active-high reset
//   START  in   1   level run request, sampled in IDLE or DONE
//   RESP   in   16  cell bank response, captured in RUN once cnt >= LAT
//   STIM   out  8   registered stimulus to the cell bank
//   BUSY   out  1   high while running
//   DONE   out  1   high while in DONE
//   PASS   out  1   signature matched GOLDEN (valid while DONE)
//   SIG    out  16  final signature (CELL_BIST_DIAG_EN only)
module cell_bist_ctrl #(
   parameter int unsigned N_PAT  = 255,
   parameter int unsigned LAT    = 0,
   parameter logic [7:0]  SEED   = 8'h01,
   parameter logic [15:0] GOLDEN = 16'h0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [15:0] RESP,
   output logic [7:0]  STIM,
   output logic        BUSY,
   output logic        DONE,
   output logic        PASS
`ifdef CELL_BIST_DIAG_EN
   ,
   output logic [15:0] SIG
`endif
);

   // An all-zero seed would lock the LFSR up.
   localparam logic [7:0]  SeedEff  = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [15:0] LastCnt  = 16'(N_PAT + LAT - 1);
   localparam logic [15:0] FlushCnt = 16'(N_PAT);
   localparam logic [15:0] LatCnt   = 16'(LAT);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [15:0] misr_q, misr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  stim_q, stim_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
`ifdef CELL_BIST_DIAG_EN
   logic [15:0] sig_q, sig_d;
`endif

   logic [7:0]  lfsr_nxt;
   logic [15:0] misr_upd;
   logic [15:0] cnt_inc;

   always_comb begin
      lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      misr_upd = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000) ^ RESP;
      // cnt never exceeds 65534, so the increment cannot wrap.
      cnt_inc  = cnt_q + 16'd1;

      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;
      stim_d  = stim_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
`ifdef CELL_BIST_DIAG_EN
      sig_d   = sig_q;
`endif

      unique case (state_q)
         StIdle, StDone: begin
            if (START) begin
               state_d = StRun;
               lfsr_d  = SeedEff;
               misr_d  = 16'h0000;
               cnt_d   = 16'h0000;
               stim_d  = SeedEff;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         StRun: begin
            cnt_d  = cnt_inc;
            lfsr_d = lfsr_nxt;
            // Next cycle shows pattern cnt+1 if it exists, otherwise flush zeros.
            stim_d = (cnt_inc < FlushCnt) ? lfsr_nxt : 8'h00;
            // Capture once the first response has emerged from the bank pipeline.
            if (cnt_inc > LatCnt) begin
               misr_d = misr_upd;
            end
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               stim_d  = 8'h00;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (misr_d == GOLDEN);
`ifdef CELL_BIST_DIAG_EN
               sig_d   = misr_d;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         lfsr_q  <= SeedEff;
         misr_q  <= 16'h0000;
         cnt_q   <= 16'h0000;
         stim_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
`ifdef CELL_BIST_DIAG_EN
         sig_q   <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         cnt_q   <= cnt_d;
         stim_q  <= stim_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
`ifdef CELL_BIST_DIAG_EN
         sig_q   <= sig_d;
`endif
      end
   end

   assign STIM = stim_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
   assign PASS = pass_q;
`ifdef CELL_BIST_DIAG_EN
   assign SIG  = sig_q;
`endif

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Testbench for cell_bist_ctrl. Several parameterisations run side by side
// on a shared clock, reset and START; each task exercises one of them.
module tb_cell_bist_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   always #5 clk = ~clk;

   int vecs = 0;
   int miscompares = 0;

   // u_a: pattern sequence, N_PAT=5 LAT=0, RESP=0
   logic [7:0] stim_a;
   logic       busy_a, done_a, pass_a;
   // u_b / u_c: signature, N_PAT=2, RESP=1, GOLDEN 0003 / 0002
   logic [7:0] stim_b, stim_c;
   logic       busy_b, done_b, pass_b, busy_c, done_c, pass_c;
   // u_d: latency/flush, N_PAT=3 LAT=2, RESP = STIM delayed 2 cycles
   logic [7:0] stim_d, bank_d1, bank_d2;
   logic       busy_d, done_d, pass_d;
   // u_e: default N_PAT=255, for mid-run reset
   logic [7:0] stim_e;
   logic       busy_e, done_e, pass_e;
`ifdef CELL_BIST_DIAG_EN
   logic [15:0] sig_a, sig_b, sig_c, sig_d, sig_e;
`endif

   always @(posedge clk) begin
      if (rst) begin
         bank_d1 <= 8'h00;
         bank_d2 <= 8'h00;
      end else begin
         bank_d1 <= stim_d;
         bank_d2 <= bank_d1;
      end
   end

   cell_bist_ctrl #(.N_PAT(5), .LAT(0), .SEED(8'h01), .GOLDEN(16'h0000)) u_a (
      .CLK(clk), .RST(rst), .START(start), .RESP(16'h0000),
      .STIM(stim_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a)
`ifdef CELL_BIST_DIAG_EN
      , .SIG(sig_a)
`endif
   );
   cell_bist_ctrl #(.N_PAT(2), .LAT(0), .SEED(8'h01), .GOLDEN(16'h0003)) u_b (
      .CLK(clk), .RST(rst), .START(start), .RESP(16'h0001),
      .STIM(stim_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b)
`ifdef CELL_BIST_DIAG_EN
      , .SIG(sig_b)
`endif
   );
   cell_bist_ctrl #(.N_PAT(2), .LAT(0), .SEED(8'h01), .GOLDEN(16'h0002)) u_c (
      .CLK(clk), .RST(rst), .START(start), .RESP(16'h0001),
      .STIM(stim_c), .BUSY(busy_c), .DONE(done_c), .PASS(pass_c)
`ifdef CELL_BIST_DIAG_EN
      , .SIG(sig_c)
`endif
   );
   cell_bist_ctrl #(.N_PAT(3), .LAT(2), .SEED(8'h01), .GOLDEN(16'h0004)) u_d (
      .CLK(clk), .RST(rst), .START(start), .RESP({8'h00, bank_d2}),
      .STIM(stim_d), .BUSY(busy_d), .DONE(done_d), .PASS(pass_d)
`ifdef CELL_BIST_DIAG_EN
      , .SIG(sig_d)
`endif
   );
   cell_bist_ctrl #(.N_PAT(255), .LAT(0), .SEED(8'h01), .GOLDEN(16'h0000)) u_e (
      .CLK(clk), .RST(rst), .START(start), .RESP(16'h0000),
      .STIM(stim_e), .BUSY(busy_e), .DONE(done_e), .PASS(pass_e)
`ifdef CELL_BIST_DIAG_EN
      , .SIG(sig_e)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      tick();
      tick();
      vecs++;
      if ({stim_a, busy_a, done_a, pass_a} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_a: got %h expected %h", {stim_a, busy_a, done_a, pass_a}, 11'h000);
      end
      vecs++;
      if ({stim_e, busy_e, done_e, pass_e} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_e: got %h expected %h", {stim_e, busy_e, done_e, pass_e}, 11'h000);
      end
`ifdef CELL_BIST_DIAG_EN
      vecs++;
      if (sig_b !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_sig: got %h expected 0000", sig_b);
      end
`endif
      rst = 1'b0;
      start = 1'b0;
      tick();
      vecs++;
      if ({busy_a, done_a, stim_a} !== 10'h000) begin
         miscompares++;
         $display("FAIL reset_idle: got %h expected %h", {busy_a, done_a, stim_a}, 10'h000);
      end
   endtask

   task automatic test_pattern_seq();
      logic [7:0] exp_pat [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         vecs++;
         if ({busy_a, done_a, stim_a} !== {1'b1, 1'b0, exp_pat[k]}) begin
            miscompares++;
            $display("FAIL pattern_%0d: got %h expected %h", k, {busy_a, done_a, stim_a},
                     {1'b1, 1'b0, exp_pat[k]});
         end
         tick();
      end
      vecs++;
      if ({busy_a, done_a, pass_a, stim_a} !== {3'b011, 8'h00}) begin
         miscompares++;
         $display("FAIL pattern_done: got %h expected %h", {busy_a, done_a, pass_a, stim_a},
                  {3'b011, 8'h00});
      end
      tick();
      vecs++;
      if ({busy_a, done_a, pass_a} !== 3'b011) begin
         miscompares++;
         $display("FAIL pattern_hold: got %b expected 011", {busy_a, done_a, pass_a});
      end
   endtask

   task automatic test_signature();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      vecs++;
      if ({busy_b, stim_b} !== {1'b1, 8'h01}) begin
         miscompares++;
         $display("FAIL sig_run0: got %h expected %h", {busy_b, stim_b}, {1'b1, 8'h01});
      end
      tick();
      vecs++;
      if ({busy_b, done_b} !== 2'b10) begin
         miscompares++;
         $display("FAIL sig_run1: got %b expected 10", {busy_b, done_b});
      end
      tick();
      // m: 0000 -> 0001 -> 0003
      vecs++;
      if ({busy_b, done_b, pass_b} !== 3'b011) begin
         miscompares++;
         $display("FAIL sig_pass: got %b expected 011", {busy_b, done_b, pass_b});
      end
      vecs++;
      if ({busy_c, done_c, pass_c} !== 3'b010) begin
         miscompares++;
         $display("FAIL sig_fail: got %b expected 010", {busy_c, done_c, pass_c});
      end
`ifdef CELL_BIST_DIAG_EN
      vecs++;
      if (sig_b !== 16'h0003) begin
         miscompares++;
         $display("FAIL sig_value: got %h expected 0003", sig_b);
      end
`endif
   endtask

   task automatic test_latency_flush();
      logic [7:0] exp_stim [5] = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00};
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         vecs++;
         if ({busy_d, done_d, stim_d} !== {1'b1, 1'b0, exp_stim[k]}) begin
            miscompares++;
            $display("FAIL latency_%0d: got %h expected %h", k, {busy_d, done_d, stim_d},
                     {1'b1, 1'b0, exp_stim[k]});
         end
         tick();
      end
      // Captures of 01, 02, 04: m = 0001 -> 0000 -> 0004
      vecs++;
      if ({busy_d, done_d, pass_d, stim_d} !== {3'b011, 8'h00}) begin
         miscompares++;
         $display("FAIL latency_done: got %h expected %h", {busy_d, done_d, pass_d, stim_d},
                  {3'b011, 8'h00});
      end
`ifdef CELL_BIST_DIAG_EN
      vecs++;
      if (sig_d !== 16'h0004) begin
         miscompares++;
         $display("FAIL latency_sig: got %h expected 0004", sig_d);
      end
`endif
   endtask

   task automatic test_mid_run_reset();
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      vecs++;
      if ({busy_e, stim_e} !== {1'b1, 8'h08}) begin
         miscompares++;
         $display("FAIL midrun_cnt3: got %h expected %h", {busy_e, stim_e}, {1'b1, 8'h08});
      end
      rst = 1'b1;
      tick();
      vecs++;
      if ({stim_e, busy_e, done_e, pass_e} !== 11'h000) begin
         miscompares++;
         $display("FAIL midrun_rst: got %h expected %h", {stim_e, busy_e, done_e, pass_e}, 11'h000);
      end
      rst = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      vecs++;
      if ({busy_e, stim_e} !== {1'b1, 8'h01}) begin
         miscompares++;
         $display("FAIL midrun_restart: got %h expected %h", {busy_e, stim_e}, {1'b1, 8'h01});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      start = 1'b1;
      for (int r = 0; r < 2; r++) begin
         tick();
         vecs++;
         if ({busy_b, done_b, stim_b} !== {2'b10, 8'h01}) begin
            miscompares++;
            $display("FAIL b2b_run%0d_p0: got %h expected %h", r, {busy_b, done_b, stim_b},
                     {2'b10, 8'h01});
         end
         tick();
         vecs++;
         if ({busy_b, done_b, stim_b} !== {2'b10, 8'h02}) begin
            miscompares++;
            $display("FAIL b2b_run%0d_p1: got %h expected %h", r, {busy_b, done_b, stim_b},
                     {2'b10, 8'h02});
         end
         tick();
         // A MISR not cleared on restart would give 000F on the second run.
         vecs++;
         if ({busy_b, done_b, pass_b} !== 3'b011) begin
            miscompares++;
            $display("FAIL b2b_run%0d_done: got %b expected 011", r, {busy_b, done_b, pass_b});
         end
`ifdef CELL_BIST_DIAG_EN
         vecs++;
         if (sig_b !== 16'h0003) begin
            miscompares++;
            $display("FAIL b2b_run%0d_sig: got %h expected 0003", r, sig_b);
         end
`endif
      end
      tick();
      vecs++;
      if ({busy_b, done_b} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_third: got %b expected 10", {busy_b, done_b});
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pattern_seq();
      test_signature();
      test_latency_flush();
      test_mid_run_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
